tx_arbiter: RTL and testbench
=============================

// Module: tx_arbiter
// PURPOSE
//  Shares the single serial Transmitter between NUM_REQ byte producers (Sender-style sources).
//  Round-robin arbitration with bursts bounded by packet end or MAX_BURST.
//  Drives the Transmitter's Data/Send_flag and watches its Busy to sequence bytes.
//  Sits between the sources and the Transmitter, in front of the Receiver/String_Detector path.
// PARAMETERS
//  NUM_REQ        4    number of requesters (2..8)
//  MAX_BURST      16   max bytes per grant before forced re-arbitration (>=1)
//  START_TIMEOUT  64   cycles to wait for Tx_Busy rise after Tx_Send before abort (>=2)
// PORTS
//  Clk          in   1          system clock, all logic on rising edge
//  Rst_n        in   1          asynchronous, active-low reset
//  Req          in   NUM_REQ    requester i has a byte pending; level, held until Ack[i]
//  Req_Data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  Req_Last     in   NUM_REQ    byte of requester i is last of its packet
//  Grant        out  NUM_REQ    one-hot current owner, 0 when idle
//  Ack          out  NUM_REQ    1-cycle pulse: owner's byte accepted by Transmitter
//  Tx_Data      out  8          byte to Transmitter, stable from Tx_Send until Busy falls
//  Tx_Send      out  1          1-cycle launch pulse to Transmitter
//  Tx_Busy      in   1          Transmitter busy
//  Timeout_Err  out  1          1-cycle pulse: Tx_Busy failed to rise within START_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, RR pointer = NUM_REQ-1 (requester 0 first).
//  FSM (registered outputs):
//   IDLE: if |Req && !Tx_Busy: pick first Req set at index (ptr+1) mod NUM_REQ, upward with wrap;
//         Grant <= onehot(pick), burst_cnt <= 0 -> LOAD. Else stay.
//   LOAD: if !Req[own]: Grant <= 0 -> IDLE (no send, no Ack, ptr unchanged).
//         else Tx_Data <= Req_Data[own], last_q <= Req_Last[own], Tx_Send=1 next cycle
//         (exactly one cycle), tmo_cnt <= 0 -> WAIT_START.
//   WAIT_START: Tx_Busy=1 -> Ack[own] pulse 1 cycle, burst_cnt++ -> WAIT_DONE.
//         tmo_cnt reaches START_TIMEOUT -> Timeout_Err pulse, Grant <= 0, ptr <= own -> IDLE;
//         no Ack, so requester retains its byte.
//   WAIT_DONE: on Tx_Busy=0: if last_q || burst_cnt==MAX_BURST || !Req[own]:
//         Grant <= 0, ptr <= own -> IDLE; else -> LOAD (same owner, no re-arbitration).
//  Latency: Req rise (idle, Busy low) -> Grant 1 cycle -> Tx_Send 2 cycles.
//  Ack per accepted byte: exactly one; never in the same cycle as Tx_Send.
//  Req changes of non-owners ignored until IDLE; Req_Data of owner sampled only in LOAD.
//  Tx_Busy high in IDLE blocks new grants (external use of Transmitter honoured).
//  Simultaneous Busy rise and timeout terminal count: Busy wins (Ack, no error).
//  Widths: burst_cnt clog2(MAX_BURST+1), tmo_cnt clog2(START_TIMEOUT+1), ptr clog2(NUM_REQ);
//  counters saturate, never wrap.
//  Reset asserted mid-transfer: outputs to 0 immediately (async); in-flight byte not Acked.
// STRUCTURE
//  Package tx_arb_pkg: state encodings (IDLE, LOAD, WAIT_START, WAIT_DONE), BYTE_W=8,
//  clog2 function.
//  Sub-module rr_picker (combinational): inputs Req, ptr; outputs one-hot pick and index.
//  Top: FSM, counters, output registers, Req_Data mux.
// TESTING
//  Transmitter model: Busy rises 2 cycles after Tx_Send, stays high 10 cycles.
//  1 Req=0010, Req_Data[1]=A5, Last=1 -> Grant=0010, one Tx_Send with Tx_Data=A5,
//    Ack=0010 once, Grant=0 after Busy falls.
//  2 Req=1111 held, all Last=1, Data=i -> Tx_Data order 00,01,02,03,00; one Ack each.
//  3 MAX_BURST=4, Req[2] never Last, Req[0] pending -> 4 bytes for 2, then Grant=0001.
//  4 Busy stuck 0 -> Timeout_Err exactly START_TIMEOUT cycles after Tx_Send, no Ack,
//    Req held, IDLE.
//  5 Rst_n low during WAIT_DONE of owner 3 -> outputs 0 same cycle;
//    after release with Req=1001, owner 0 granted first.
//  6 Req[1] dropped in LOAD -> no Tx_Send, no Ack, Grant=0 next cycle.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Purpose: shared types, widths and helpers for the transmitter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tx_arb_pkg;

  localparam int BYTE_W = 8;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_e;

  // Ceiling log2 with a floor of 1, so a 1-bit field is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose: combinational round-robin pick of the first request above the pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is only meaningful when pick_vld is high.
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_vld
);

  // One spare bit so ptr + k never overflows before the modulo fold.
  localparam logic [PTR_W:0] NUM_REQ_C = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] cand;

  // Scan ptr+1, ptr+2, ... with wrap; the first set request wins.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_C) begin
        cand = cand - NUM_REQ_C;
      end
      if (!pick_vld && req[cand[PTR_W-1:0]]) begin
        pick_vld                   = 1'b1;
        pick_oh[cand[PTR_W-1:0]]   = 1'b1;
        pick_idx                   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Purpose: round-robin sharing of one serial Transmitter among NUM_REQ byte sources.
// Latency: Req -> Grant 1 cycle, Req -> Tx_Send 2 cycles; one Ack per accepted byte.
// Backpressure: Tx_Busy stalls the owner and blocks new grants; missing Busy rise aborts.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [BYTE_W*NUM_REQ-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]        Req_Last,
  output logic [NUM_REQ-1:0]        Grant,
  output logic [NUM_REQ-1:0]        Ack,
  output logic [BYTE_W-1:0]         Tx_Data,
  output logic                      Tx_Send,
  input  logic                      Tx_Busy,
  output logic                      Timeout_Err
);

  localparam int PTR_W   = clog2(NUM_REQ);
  localparam int BURST_W = clog2(MAX_BURST + 1);
  localparam int TMO_W   = clog2(START_TIMEOUT + 1);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);
  localparam logic [TMO_W-1:0]   TMO_C       = TMO_W'(START_TIMEOUT);
  // Pointer starts on the last requester so requester 0 is served first.
  localparam logic [PTR_W-1:0]   PTR_RST     = PTR_W'(NUM_REQ - 1);

  state_e               state_q,     state_d;
  logic [NUM_REQ-1:0]   grant_q,     grant_d;
  logic [NUM_REQ-1:0]   ack_q,       ack_d;
  logic [BYTE_W-1:0]    tx_data_q,   tx_data_d;
  logic                 tx_send_q,   tx_send_d;
  logic                 tmo_err_q,   tmo_err_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q,   tmo_cnt_d;
  logic [PTR_W-1:0]     ptr_q,       ptr_d;
  logic [PTR_W-1:0]     own_q,       own_d;
  logic                 last_q,      last_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_vld;

  logic                 own_req;
  logic                 own_last;
  logic [BYTE_W-1:0]    own_data;
  logic [BURST_W-1:0]   burst_inc;
  logic [TMO_W-1:0]     tmo_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req      (Req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Select the current owner's request, data byte and last flag.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own_q == PTR_W'(i)) begin
        own_req  = Req[i];
        own_last = Req_Last[i];
        own_data = Req_Data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Saturating increments: counters stick at their terminal value instead of wrapping.
  always_comb begin
    burst_inc = (burst_cnt_q == MAX_BURST_C) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
    tmo_inc   = (tmo_cnt_q == TMO_C) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  end

  // Next-state and registered-output computation for the grant/launch/ack sequence.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ack_d       = '0;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    tmo_err_d   = 1'b0;
    burst_cnt_d = burst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        // An externally busy Transmitter holds off any new grant.
        if (pick_vld && !Tx_Busy) begin
          grant_d     = pick_oh;
          own_d       = pick_idx;
          burst_cnt_d = '0;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        if (!own_req) begin
          // Owner withdrew: release without launching; pointer keeps its place.
          grant_d = '0;
          state_d = IDLE;
        end else begin
          tx_data_d = own_data;
          last_d    = own_last;
          tx_send_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = WAIT_START;
        end
      end

      WAIT_START: begin
        // Busy is checked first so a rise on the terminal-count cycle still counts.
        if (Tx_Busy) begin
          ack_d       = grant_q;
          burst_cnt_d = burst_inc;
          state_d     = WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TMO_C) begin
            // No Ack, so the requester keeps its byte for a later retry.
            tmo_err_d = 1'b1;
            grant_d   = '0;
            ptr_d     = own_q;
            state_d   = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!Tx_Busy) begin
          if (last_q || (burst_cnt_q == MAX_BURST_C) || !own_req) begin
            grant_d = '0;
            ptr_d   = own_q;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset clears every output immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      burst_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      ptr_q       <= PTR_RST;
      own_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      tmo_err_q   <= tmo_err_d;
      burst_cnt_q <= burst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      last_q      <= last_d;
    end
  end

  assign Grant       = grant_q;
  assign Ack         = ack_q;
  assign Tx_Data     = tx_data_q;
  assign Tx_Send     = tx_send_q;
  assign Timeout_Err = tmo_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Purpose: scoreboard bench for tx_arbiter with a Transmitter model and byte sources.
// Latency: expects Grant 1 cycle and Tx_Send 2 cycles after a request from idle.
// Backpressure: Transmitter model raises Busy 2 cycles after Tx_Send for 10 cycles.
module tb_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;
  localparam int ST = 8;

  logic            Clk;
  logic            Rst_n;
  logic [NR-1:0]   Req;
  logic [8*NR-1:0] Req_Data;
  logic [NR-1:0]   Req_Last;
  logic [NR-1:0]   Grant;
  logic [NR-1:0]   Ack;
  logic [7:0]      Tx_Data;
  logic            Tx_Send;
  logic            Tx_Busy;
  logic            Timeout_Err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_send_cyc = 0;
  bit xmtr_en = 1'b1;

  // Per-requester byte sources: {last, data}.
  logic [8:0] src_mem [NR][16];
  int         src_head [NR];
  int         src_cnt  [NR];

  // Scoreboard queues filled by the stimulus.
  logic [11:0] exp_send[$];   // {grant, data}
  logic [3:0]  exp_ack[$];
  int          exp_tmo[$];    // cycles from Tx_Send to Timeout_Err

  tx_arbiter #(
    .NUM_REQ       (NR),
    .MAX_BURST     (MB),
    .START_TIMEOUT (ST)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Req         (Req),
    .Req_Data    (Req_Data),
    .Req_Last    (Req_Last),
    .Grant       (Grant),
    .Ack         (Ack),
    .Tx_Data     (Tx_Data),
    .Tx_Send     (Tx_Send),
    .Tx_Busy     (Tx_Busy),
    .Timeout_Err (Timeout_Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic refresh_req();
    for (int i = 0; i < NR; i++) begin
      if (src_cnt[i] > 0) begin
        Req[i]            = 1'b1;
        Req_Data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
        Req_Last[i]       = src_mem[i][src_head[i]][8];
      end else begin
        Req[i]            = 1'b0;
        Req_Data[8*i +: 8] = 8'h00;
        Req_Last[i]       = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic last);
    src_mem[i][src_head[i] + src_cnt[i]] = {last, d};
    src_cnt[i]++;
  endtask

  task automatic expect_byte(input logic [3:0] g, input logic [7:0] d);
    exp_send.push_back({g, d});
    exp_ack.push_back(g);
  endtask

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_cnt[i]  = 0;
    end
    refresh_req();
    #1;
    check({Grant, Ack, Tx_Data, Tx_Send, Timeout_Err} == '0, "reset_outputs",
          32'({Grant, Ack, Tx_Data, Tx_Send, Timeout_Err}), 32'h0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // kind 0: Grant == mask, 1: Ack == mask, 2: Timeout_Err pulse.
  task automatic wait_for(input int kind, input logic [3:0] mask, input int budget, input string name);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge Clk);
      n++;
      case (kind)
        0:       hit = (Grant == mask);
        1:       hit = (Ack == mask);
        default: hit = Timeout_Err;
      endcase
    end
    check(hit, name, 32'(n), 32'(budget));
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n;
    int stable;
    bit busy_src;
    n      = 0;
    stable = 0;
    while (stable < 3 && n < budget) begin
      @(negedge Clk);
      n++;
      busy_src = 1'b0;
      for (int i = 0; i < NR; i++) if (src_cnt[i] > 0) busy_src = 1'b1;
      if (!busy_src && Grant == '0 && !Tx_Busy) stable++;
      else stable = 0;
    end
    check(stable >= 3, name, 32'(n), 32'(budget));
  endtask

  task automatic check_empty(input string name);
    check(exp_send.size() == 0 && exp_ack.size() == 0 && exp_tmo.size() == 0, name,
          32'(exp_send.size() + exp_ack.size() + exp_tmo.size()), 32'h0);
  endtask

  // Transmitter model: Busy high for cycles s+2 .. s+11 after a Tx_Send in cycle s.
  initial begin
    Tx_Busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (Tx_Send && xmtr_en) begin
        @(posedge Clk);
        @(posedge Clk);
        #1 Tx_Busy = 1'b1;
        repeat (10) @(posedge Clk);
        #1 Tx_Busy = 1'b0;
      end
    end
  end

  // Requester model: an Ack retires the head byte of that source.
  initial begin
    forever begin
      @(negedge Clk);
      if (Ack != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (Ack[i] && src_cnt[i] > 0) begin
            src_head[i]++;
            src_cnt[i]--;
          end
        end
        refresh_req();
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a launch, ack or timeout.
  initial begin
    logic [11:0] e;
    logic [3:0]  a;
    int          g;
    forever begin
      @(negedge Clk);
      if (Tx_Send) begin
        last_send_cyc = cyc;
        if (exp_send.size() == 0) begin
          check(1'b0, "unexpected_send", 32'({Grant, Tx_Data}), 32'h0);
        end else begin
          e = exp_send.pop_front();
          check({Grant, Tx_Data} == e, "send_grant_data", 32'({Grant, Tx_Data}), 32'(e));
        end
      end
      if (Ack != '0) begin
        if (exp_ack.size() == 0) begin
          check(1'b0, "unexpected_ack", 32'(Ack), 32'h0);
        end else begin
          a = exp_ack.pop_front();
          check(Ack == a, "ack_mask", 32'(Ack), 32'(a));
        end
      end
      if (Tx_Send || Ack != '0) begin
        check(!(Tx_Send && Ack != '0), "ack_with_send", 32'({Tx_Send, Ack}), 32'h0);
      end
      if (Timeout_Err) begin
        if (exp_tmo.size() == 0) begin
          check(1'b0, "unexpected_timeout", 32'(cyc - last_send_cyc), 32'h0);
        end else begin
          g = exp_tmo.pop_front();
          check((cyc - last_send_cyc) == g, "timeout_gap", 32'(cyc - last_send_cyc), 32'(g));
        end
      end
    end
  end

  // Directed tests.
  initial begin
    Rst_n    = 1'b0;
    Req      = '0;
    Req_Data = '0;
    Req_Last = '0;

    // 1: single byte from requester 1, with latency checks.
    do_reset();
    @(negedge Clk);
    load(1, 8'hA5, 1'b1);
    refresh_req();
    expect_byte(4'b0010, 8'hA5);
    wait_for(0, 4'b0010, 1, "t1_grant_latency");
    @(negedge Clk);
    check(Tx_Send == 1'b1, "t1_send_latency", 32'(Tx_Send), 32'h1);
    wait_quiet(60, "t1_idle");
    check_empty("t1_drained");

    // 2: all four request, requester 0 has two bytes -> 00,01,02,03,00.
    do_reset();
    @(negedge Clk);
    load(0, 8'h00, 1'b1);
    load(0, 8'h00, 1'b1);
    load(1, 8'h01, 1'b1);
    load(2, 8'h02, 1'b1);
    load(3, 8'h03, 1'b1);
    refresh_req();
    expect_byte(4'b0001, 8'h00);
    expect_byte(4'b0010, 8'h01);
    expect_byte(4'b0100, 8'h02);
    expect_byte(4'b1000, 8'h03);
    expect_byte(4'b0001, 8'h00);
    wait_quiet(300, "t2_idle");
    check_empty("t2_drained");

    // 3: requester 2 never Last, burst capped at 4, requester 0 served in between.
    do_reset();
    @(negedge Clk);
    for (int k = 0; k < 6; k++) load(2, 8'(8'h20 + k), 1'b0);
    refresh_req();
    for (int k = 0; k < 4; k++) expect_byte(4'b0100, 8'(8'h20 + k));
    expect_byte(4'b0001, 8'h0F);
    expect_byte(4'b0100, 8'h24);
    expect_byte(4'b0100, 8'h25);
    wait_for(0, 4'b0100, 5, "t3_first_grant");
    load(0, 8'h0F, 1'b1);
    refresh_req();
    wait_quiet(400, "t3_idle");
    check_empty("t3_drained");

    // 4: Busy never rises -> timeout, no Ack, request still held.
    do_reset();
    xmtr_en = 1'b0;
    @(negedge Clk);
    load(1, 8'h3C, 1'b1);
    refresh_req();
    exp_send.push_back({4'b0010, 8'h3C});
    exp_tmo.push_back(ST);
    wait_for(2, 4'b0000, 40, "t4_timeout");
    check(Grant == 4'b0000, "t4_grant_released", 32'(Grant), 32'h0);
    check(src_cnt[1] == 1 && Req[1], "t4_req_held", 32'(src_cnt[1]), 32'h1);
    src_cnt[1] = 0;
    refresh_req();
    xmtr_en = 1'b1;
    wait_quiet(30, "t4_idle");
    check_empty("t4_drained");

    // 5: reset during WAIT_DONE of owner 3, then requester 0 wins first.
    do_reset();
    @(negedge Clk);
    load(3, 8'h77, 1'b1);
    refresh_req();
    expect_byte(4'b1000, 8'h77);
    wait_for(1, 4'b1000, 30, "t5_ack");
    repeat (3) @(negedge Clk);
    check(Grant == 4'b1000 && Tx_Data == 8'h77, "t5_owner_mid", 32'({Grant, Tx_Data}), 32'h877);
    check_empty("t5_pre_reset");
    do_reset();
    @(negedge Clk);
    load(0, 8'h10, 1'b1);
    load(3, 8'h33, 1'b1);
    refresh_req();
    expect_byte(4'b0001, 8'h10);
    expect_byte(4'b1000, 8'h33);
    wait_quiet(200, "t5_idle");
    check_empty("t5_drained");

    // 6: requester 1 drops its request while in LOAD.
    do_reset();
    @(negedge Clk);
    load(1, 8'h66, 1'b1);
    refresh_req();
    wait_for(0, 4'b0010, 5, "t6_grant");
    src_cnt[1] = 0;
    refresh_req();
    @(negedge Clk);
    check(Grant == 4'b0000 && !Tx_Send, "t6_drop_release", 32'({Grant, Tx_Send}), 32'h0);
    wait_quiet(30, "t6_idle");
    check_empty("t6_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
